// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM port scheduler: channel state codes and owner encoding.
// No logic; types only.
// Imported by the channel sequencer and the top level.
package sdram_sched_pkg;

    // Channel state codes, also exported on Wr_state / Rd_state.
    typedef enum logic [2:0] {
        ST_STREAM = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_NIOS   = 3'd4
    } chan_state_t;

    // Owner of a channel; also the value driven on the data mux selects.
    typedef enum logic {
        OWN_STREAM = 1'b0,
        OWN_NIOS   = 1'b1
    } owner_t;

endpackage

// File: rtl/sdram_port_scheduler_if.sv
// Bundle of request, strobe and FIFO-control signals around the SDRAM port scheduler.
// No logic; wiring only.
// master = requester/stream side driving the scheduler, slave = the scheduler itself.
interface sdram_port_scheduler_if;
    logic       Nios_wr_req;
    logic       Nios_rd_req;
    logic       Frame_start;
    logic       LCD_vblank;
    logic       Cam_wr_en;
    logic       LCD_rd_en;
    logic       Nios_wr_en;
    logic       Nios_rd_en;
    logic       SDRAM_write_en;
    logic       SDRAM_read_en;
    logic       SDRAM_wr_src;
    logic       SDRAM_rd_src;
    logic       SDRAM_WR_Load;
    logic       SDRAM_RD_Load;
    logic       Wr_grant;
    logic       Rd_grant;
    logic [2:0] Wr_state;
    logic [2:0] Rd_state;

    modport master (
        output Nios_wr_req, Nios_rd_req, Frame_start, LCD_vblank,
               Cam_wr_en, LCD_rd_en, Nios_wr_en, Nios_rd_en,
        input  SDRAM_write_en, SDRAM_read_en, SDRAM_wr_src, SDRAM_rd_src,
               SDRAM_WR_Load, SDRAM_RD_Load, Wr_grant, Rd_grant, Wr_state, Rd_state
    );

    modport slave (
        input  Nios_wr_req, Nios_rd_req, Frame_start, LCD_vblank,
               Cam_wr_en, LCD_rd_en, Nios_wr_en, Nios_rd_en,
        output SDRAM_write_en, SDRAM_read_en, SDRAM_wr_src, SDRAM_rd_src,
               SDRAM_WR_Load, SDRAM_RD_Load, Wr_grant, Rd_grant, Wr_state, Rd_state
    );
endinterface

// File: rtl/sdram_channel_seq.sv
// One FIFO channel's ownership sequencer: STREAM/DRAIN/LOAD/SETTLE/NIOS with load pulse and settle delay.
// Latency: boundary (or request drop in NIOS) to new owner enabled = 1 + LOAD_CYCLES + SETTLE_CYCLES cycles.
// No backpressure: strobes outside the owner's pass states are dropped; SDRAM_SCHED_TIMEOUT_EN bounds the DRAIN wait.
module sdram_channel_seq
    import sdram_sched_pkg::*;
#(
    parameter int LOAD_CYCLES    = 4,
    parameter int SETTLE_CYCLES  = 1048575,
    parameter int CNT_W          = 20,
    parameter int TIMEOUT_CYCLES = 2097151
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       req,
    input  logic       boundary,
    input  logic       stream_en,
    input  logic       nios_en,
    output logic       gated_en,
    output logic       src,
    output logic       load,
    output logic       grant,
    output logic [2:0] state_code
);

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Phase lengths of zero would make the counter compare unreachable.
    if (LOAD_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sdram_channel_seq: phase lengths must be >= 1");
    end

    chan_state_t      state;
    owner_t           tgt;
    logic [CNT_W-1:0] cnt;
    logic             drain_expired;

`ifdef SDRAM_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign drain_expired = (cnt == TIMEOUT_LAST);
`else
    assign drain_expired = 1'b0;
`endif

    assign state_code = state;

    // Ownership FSM; counter restarts on every state entry, outputs registered alongside the state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_LOAD;
            tgt   <= OWN_STREAM;
            cnt   <= '0;
            load  <= 1'b1;
            src   <= 1'b0;
            grant <= 1'b0;
        end else begin
            case (state)
                ST_STREAM: begin
                    if (req) begin
                        state <= ST_DRAIN;
                        tgt   <= OWN_NIOS;
                        cnt   <= '0;
                    end
                end
                ST_DRAIN: begin
                    // A dropped request beats a boundary seen on the same edge.
                    if (!req) begin
                        state <= ST_STREAM;
                        tgt   <= OWN_STREAM;
                        cnt   <= '0;
                    end else if (boundary || drain_expired) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                        load  <= 1'b1;
                        src   <= (tgt == OWN_NIOS);
                    end else begin
`ifdef SDRAM_SCHED_TIMEOUT_EN
                        cnt <= cnt + CNT_ONE;
`endif
                    end
                end
                ST_LOAD: begin
                    if (cnt == LOAD_LAST) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                        load  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    // Request level is not consulted here; the switch always completes.
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (tgt == OWN_NIOS) begin
                            state <= ST_NIOS;
                            grant <= 1'b1;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_NIOS: begin
                    // Handing back to the stream needs no boundary: the stream FIFO is reloaded anyway.
                    if (!req) begin
                        state <= ST_LOAD;
                        tgt   <= OWN_STREAM;
                        cnt   <= '0;
                        load  <= 1'b1;
                        src   <= 1'b0;
                        grant <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                    tgt   <= OWN_STREAM;
                    cnt   <= '0;
                    load  <= 1'b1;
                    src   <= 1'b0;
                    grant <= 1'b0;
                end
            endcase
        end
    end

    // Pass only the current owner's strobe; everything is blocked during LOAD/SETTLE.
    always_comb begin
        gated_en = 1'b0;
        case (state)
            ST_STREAM, ST_DRAIN: gated_en = stream_en;
            ST_NIOS:             gated_en = nios_en;
            default:             gated_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Sequences ownership of the shared SDRAM frame-buffer FIFOs between camera/LCD streams and Nios (option: SDRAM_SCHED_TIMEOUT_EN).
// Latency: owner switch completes 1 + LOAD_CYCLES + SETTLE_CYCLES cycles after the boundary; enables are combinational.
// No backpressure: strobes arriving while a channel is switching are dropped, not queued.
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int LOAD_CYCLES    = 4,
    parameter int SETTLE_CYCLES  = 1048575,
    parameter int CNT_W          = 20,
    parameter int TIMEOUT_CYCLES = 2097151
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    sdram_port_scheduler_if.slave  bus
);

    logic vblank_q;
    logic vblank_rise;

    // Remember last LCD_vblank so the read boundary is the start of blanking, not its level.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= bus.LCD_vblank;
        end
    end

    assign vblank_rise = bus.LCD_vblank & ~vblank_q;

    sdram_channel_seq #(
        .LOAD_CYCLES    (LOAD_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wr_seq (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .req        (bus.Nios_wr_req),
        .boundary   (bus.Frame_start),
        .stream_en  (bus.Cam_wr_en),
        .nios_en    (bus.Nios_wr_en),
        .gated_en   (bus.SDRAM_write_en),
        .src        (bus.SDRAM_wr_src),
        .load       (bus.SDRAM_WR_Load),
        .grant      (bus.Wr_grant),
        .state_code (bus.Wr_state)
    );

    sdram_channel_seq #(
        .LOAD_CYCLES    (LOAD_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_seq (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .req        (bus.Nios_rd_req),
        .boundary   (vblank_rise),
        .stream_en  (bus.LCD_rd_en),
        .nios_en    (bus.Nios_rd_en),
        .gated_en   (bus.SDRAM_read_en),
        .src        (bus.SDRAM_rd_src),
        .load       (bus.SDRAM_RD_Load),
        .grant      (bus.Rd_grant),
        .state_code (bus.Rd_state)
    );

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Testbench for sdram_port_scheduler with short phases (load 2, settle 8, timeout 20).
// Expected per-cycle outputs come from the phase timeline: j cycles after a handover edge.
// Strobes are randomized every cycle; gating expectations follow the owner of each phase.
module tb_sdram_port_scheduler;

    localparam int L = 2;
    localparam int S = 8;
    localparam int T = 20;

    logic Clock  = 1'b0;
    logic Resetn = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 Clock = ~Clock;

    sdram_port_scheduler_if bus();

    sdram_port_scheduler #(
        .LOAD_CYCLES    (L),
        .SETTLE_CYCLES  (S),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    // Phase code j cycles after the edge that started a handover.
    function automatic logic [2:0] exp_state(int j, bit to_nios);
        if (j < L)     return 3'd2;
        if (j < L + S) return 3'd3;
        return to_nios ? 3'd4 : 3'd0;
    endfunction

    // Which strobe an owner lets through in a given phase.
    function automatic logic exp_gate(logic [2:0] st, logic s_en, logic n_en);
        case (st)
            3'd0, 3'd1: return s_en;
            3'd4:       return n_en;
            default:    return 1'b0;
        endcase
    endfunction

    // Expected {state, load, src, grant, enable} of a channel during a handover.
    function automatic logic [6:0] exp_vec(int j, bit to_nios, logic s_en, logic n_en);
        logic [2:0] st;
        st = exp_state(j, to_nios);
        return {st, st == 3'd2, to_nios, st == 3'd4, exp_gate(st, s_en, n_en)};
    endfunction

    function automatic logic [6:0] wr_obs();
        return {bus.Wr_state, bus.SDRAM_WR_Load, bus.SDRAM_wr_src, bus.Wr_grant, bus.SDRAM_write_en};
    endfunction

    function automatic logic [6:0] rd_obs();
        return {bus.Rd_state, bus.SDRAM_RD_Load, bus.SDRAM_rd_src, bus.Rd_grant, bus.SDRAM_read_en};
    endfunction

    // Advance one clock, then apply fresh random strobes and settle before sampling.
    task automatic next_cycle();
        @(posedge Clock);
        @(negedge Clock);
        bus.Cam_wr_en  = 1'($urandom_range(0, 1));
        bus.LCD_rd_en  = 1'($urandom_range(0, 1));
        bus.Nios_wr_en = 1'($urandom_range(0, 1));
        bus.Nios_rd_en = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic test_reset();
        #2;
        Resetn = 1'b0;
        @(negedge Clock);
        bus.Cam_wr_en  = 1'b1;
        bus.LCD_rd_en  = 1'b1;
        bus.Nios_wr_en = 1'b1;
        bus.Nios_rd_en = 1'b1;
        #1;
        n_run++;
        if ({wr_obs(), rd_obs()} !== {7'b010_1_0_0_0, 7'b010_1_0_0_0}) begin
            n_fail++;
            $display("FAIL reset_values got=%b required=%b", {wr_obs(), rd_obs()}, {7'b010_1_0_0_0, 7'b010_1_0_0_0});
        end
        Resetn = 1'b1;
        for (int j = 0; j <= L + S + 2; j++) begin
            if (j > 0) next_cycle();
            n_run++;
            if (wr_obs() !== exp_vec(j, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en)) begin
                n_fail++;
                $display("FAIL startup_wr j=%0d got=%b required=%b", j, wr_obs(), exp_vec(j, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en));
            end
            n_run++;
            if (rd_obs() !== exp_vec(j, 1'b0, bus.LCD_rd_en, bus.Nios_rd_en)) begin
                n_fail++;
                $display("FAIL startup_rd j=%0d got=%b required=%b", j, rd_obs(), exp_vec(j, 1'b0, bus.LCD_rd_en, bus.Nios_rd_en));
            end
        end
    endtask

    task automatic test_wr_handover();
        int d;
        d = $urandom_range(2, 8);
        bus.Nios_wr_req = 1'b1;
        for (int k = 0; k < d; k++) begin
            next_cycle();
            n_run++;
            if ({wr_obs(), rd_obs()} !== {3'd1, 3'b000, bus.Cam_wr_en, 3'd0, 3'b000, bus.LCD_rd_en}) begin
                n_fail++;
                $display("FAIL wr_drain k=%0d got=%b required=%b", k, {wr_obs(), rd_obs()},
                         {3'd1, 3'b000, bus.Cam_wr_en, 3'd0, 3'b000, bus.LCD_rd_en});
            end
        end
        bus.Frame_start = 1'b1;
        next_cycle();
        bus.Frame_start = 1'b0;
        for (int j = 0; j <= L + S + 2; j++) begin
            if (j > 0) next_cycle();
            n_run++;
            if (wr_obs() !== exp_vec(j, 1'b1, bus.Cam_wr_en, bus.Nios_wr_en)) begin
                n_fail++;
                $display("FAIL wr_handover j=%0d got=%b required=%b", j, wr_obs(), exp_vec(j, 1'b1, bus.Cam_wr_en, bus.Nios_wr_en));
            end
        end
    endtask

    task automatic test_wr_release();
        bus.Nios_wr_req = 1'b0;
        next_cycle();
        for (int j = 0; j <= L + S + 2; j++) begin
            if (j > 0) next_cycle();
            n_run++;
            if (wr_obs() !== exp_vec(j, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en)) begin
                n_fail++;
                $display("FAIL wr_release j=%0d got=%b required=%b", j, wr_obs(), exp_vec(j, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en));
            end
        end
    endtask

    task automatic test_rd_handover();
        int d;
        d = $urandom_range(3, 8);
        // Blanking already in progress when the request arrives: must wait for the next start of blanking.
        bus.LCD_vblank  = 1'b1;
        bus.Nios_rd_req = 1'b1;
        for (int k = 0; k < d + 1; k++) begin
            if (k == d) bus.LCD_vblank = 1'b0;
            next_cycle();
            n_run++;
            if (rd_obs() !== {3'd1, 3'b000, bus.LCD_rd_en}) begin
                n_fail++;
                $display("FAIL rd_drain k=%0d got=%b required=%b", k, rd_obs(), {3'd1, 3'b000, bus.LCD_rd_en});
            end
        end
        bus.LCD_vblank = 1'b1;
        next_cycle();
        for (int j = 0; j <= L + S + 2; j++) begin
            if (j > 0) next_cycle();
            n_run++;
            if (rd_obs() !== exp_vec(j, 1'b1, bus.LCD_rd_en, bus.Nios_rd_en)) begin
                n_fail++;
                $display("FAIL rd_handover j=%0d got=%b required=%b", j, rd_obs(), exp_vec(j, 1'b1, bus.LCD_rd_en, bus.Nios_rd_en));
            end
        end
        bus.Nios_rd_req = 1'b0;
        next_cycle();
        for (int j = 0; j <= L + S + 2; j++) begin
            if (j > 0) next_cycle();
            n_run++;
            if (rd_obs() !== exp_vec(j, 1'b0, bus.LCD_rd_en, bus.Nios_rd_en)) begin
                n_fail++;
                $display("FAIL rd_release j=%0d got=%b required=%b", j, rd_obs(), exp_vec(j, 1'b0, bus.LCD_rd_en, bus.Nios_rd_en));
            end
        end
        bus.LCD_vblank = 1'b0;
    endtask

    task automatic test_drop_vs_boundary();
        bus.Nios_wr_req = 1'b1;
        repeat (3) next_cycle();
        bus.Nios_wr_req = 1'b0;
        bus.Frame_start = 1'b1;
        next_cycle();
        bus.Frame_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            n_run++;
            if (wr_obs() !== {3'd0, 3'b000, bus.Cam_wr_en}) begin
                n_fail++;
                $display("FAIL drop_vs_boundary k=%0d got=%b required=%b", k, wr_obs(), {3'd0, 3'b000, bus.Cam_wr_en});
            end
        end
    endtask

    task automatic test_drop_during_switch();
        int drop_at;
        drop_at = $urandom_range(0, L + S - 1);
        bus.Nios_wr_req = 1'b1;
        next_cycle();
        bus.Frame_start = 1'b1;
        next_cycle();
        bus.Frame_start = 1'b0;
        for (int j = 0; j <= 2 * (L + S) + 2; j++) begin
            if (j > 0) next_cycle();
            if (j == drop_at) bus.Nios_wr_req = 1'b0;
            n_run++;
            if (j <= L + S) begin
                if (wr_obs() !== exp_vec(j, 1'b1, bus.Cam_wr_en, bus.Nios_wr_en)) begin
                    n_fail++;
                    $display("FAIL drop_in_switch j=%0d got=%b required=%b", j, wr_obs(), exp_vec(j, 1'b1, bus.Cam_wr_en, bus.Nios_wr_en));
                end
            end else begin
                if (wr_obs() !== exp_vec(j - L - S - 1, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en)) begin
                    n_fail++;
                    $display("FAIL drop_in_switch_exit j=%0d got=%b required=%b", j, wr_obs(),
                             exp_vec(j - L - S - 1, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.Nios_wr_req = 1'b1;
        next_cycle();
        bus.Frame_start = 1'b1;
        next_cycle();
        bus.Frame_start = 1'b0;
        repeat (L + 1) next_cycle();
        n_run++;
        if (bus.Wr_state !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_mid_setup got=%0d required=3", bus.Wr_state);
        end
        // Assert reset between clock edges: outputs must change with no clock.
        #1;
        Resetn = 1'b0;
        #1;
        n_run++;
        if ({wr_obs(), rd_obs()} !== {6'b010_1_0_0, bus.SDRAM_write_en, 6'b010_1_0_0, bus.SDRAM_read_en} ||
            bus.SDRAM_write_en !== 1'b0 || bus.SDRAM_read_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%b required=%b", {wr_obs(), rd_obs()}, {7'b010_1_0_0_0, 7'b010_1_0_0_0});
        end
        bus.Nios_wr_req = 1'b0;
        repeat (2) next_cycle();
        Resetn = 1'b1;
        for (int j = 0; j <= L + S + 2; j++) begin
            if (j > 0) next_cycle();
            n_run++;
            if ({wr_obs(), rd_obs()} !== {exp_vec(j, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en), exp_vec(j, 1'b0, bus.LCD_rd_en, bus.Nios_rd_en)}) begin
                n_fail++;
                $display("FAIL reset_rerun j=%0d got=%b required=%b", j, {wr_obs(), rd_obs()},
                         {exp_vec(j, 1'b0, bus.Cam_wr_en, bus.Nios_wr_en), exp_vec(j, 1'b0, bus.LCD_rd_en, bus.Nios_rd_en)});
            end
        end
    endtask

`ifdef SDRAM_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bus.Nios_wr_req = 1'b1;
        next_cycle();
        for (int k = 0; k <= T; k++) begin
            if (k > 0) next_cycle();
            n_run++;
            if (bus.Wr_state !== ((k < T) ? 3'd1 : 3'd2)) begin
                n_fail++;
                $display("FAIL timeout k=%0d got=%0d required=%0d", k, bus.Wr_state, (k < T) ? 1 : 2);
            end
        end
        bus.Nios_wr_req = 1'b0;
        repeat (2 * (L + S) + 4) next_cycle();
        n_run++;
        if (bus.Wr_state !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_exit got=%0d required=0", bus.Wr_state);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Nios_wr_req = 1'b0;
        bus.Nios_rd_req = 1'b0;
        bus.Frame_start = 1'b0;
        bus.LCD_vblank  = 1'b0;
        bus.Cam_wr_en   = 1'b0;
        bus.LCD_rd_en   = 1'b0;
        bus.Nios_wr_en  = 1'b0;
        bus.Nios_rd_en  = 1'b0;
        test_reset();
        for (int r = 0; r < 3; r++) begin
            test_wr_handover();
            test_wr_release();
        end
        test_rd_handover();
        test_drop_vs_boundary();
        test_drop_during_switch();
        test_reset_mid();
`ifdef SDRAM_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_scheduler.md
# sdram_port_scheduler

- Sequences ownership of the shared 4-port SDRAM frame-buffer FIFOs.
  - Write side: camera pixel stream vs Nios imageline writes.
  - Read side: LCD scan-out vs Nios imageline reads.
- Switches owners only at safe boundaries: camera frame start for writes, LCD vertical blanking for reads.
- Each handover pulses the FIFO load/reset and waits a settle period before the new owner's enables pass.
- Replaces manual source-select and reload juggling inside the LCD/camera top-level component.

## Interface
Parameters:
- LOAD_CYCLES, 4: cycles WR_Load/RD_Load held high per handover (≥1).
- SETTLE_CYCLES, 1048575: cycles after load release before the new owner is enabled (≥1).
- CNT_W, 20: width of the delay counter; must hold max(LOAD_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES).
- TIMEOUT_CYCLES, 2097151: boundary-wait limit; only used with SDRAM_SCHED_TIMEOUT_EN. CNT_W must be widened to cover it.

Ports:
- Clock  in  1  system clock (50 MHz).
- Resetn  in  1  asynchronous, active-low reset.
- Nios_wr_req  in  1  level; Nios requests the write side.
- Nios_rd_req  in  1  level; Nios requests the read side.
- Frame_start  in  1  one-cycle pulse at a camera frame boundary.
- LCD_vblank  in  1  high while the LCD is in vertical blanking.
- Cam_wr_en  in  1  camera data-valid strobe.
- LCD_rd_en  in  1  LCD read strobe.
- Nios_wr_en  in  1  Nios write strobe.
- Nios_rd_en  in  1  Nios read strobe.
- SDRAM_write_en  out  1  gated write strobe to the FIFO.
- SDRAM_read_en  out  1  gated read strobe to the FIFO.
- SDRAM_wr_src  out  1  write data mux select; 1 = Nios.
- SDRAM_rd_src  out  1  read data mux select; 1 = Nios.
- SDRAM_WR_Load  out  1  write FIFO load/reset.
- SDRAM_RD_Load  out  1  read FIFO load/reset.
- Wr_grant  out  1  Nios owns the write side and may strobe.
- Rd_grant  out  1  Nios owns the read side and may strobe.
- Wr_state  out  3  write channel state code.
- Rd_state  out  3  read channel state code.

## Operation
Two independent, identical channel FSMs: write (boundary = Frame_start) and read (boundary = rising edge of LCD_vblank, detected internally).

States and codes: STREAM=0, DRAIN=1, LOAD=2, SETTLE=3, NIOS=4. A target-owner bit `tgt` records the owner being switched to.
- STREAM
  - Stream owns the channel.
  - Request high → DRAIN, tgt=Nios.
- DRAIN
  - Stream enables still pass.
  - Boundary → LOAD.
  - Request dropped → STREAM. Drop wins over a simultaneous boundary.
- LOAD
  - Load=1, both enables forced 0.
  - src switches to tgt on entry.
  - After LOAD_CYCLES → SETTLE.
- SETTLE
  - Load=0, enables forced 0.
  - After SETTLE_CYCLES: tgt=Nios → NIOS; tgt=stream → STREAM.
- NIOS
  - grant=1, Nios enables pass.
  - Request low → LOAD with tgt=stream. No boundary wait is needed.

Gating and requests:
- Enable gating is combinational from state and the selected source's strobe. Strobes arriving outside the owner's pass states are dropped, never queued.
- The request level is ignored during LOAD/SETTLE.
  - If the request drops during a switch to Nios, the sequence still completes into NIOS, then exits the next cycle.

Reset (Resetn low):
- Both channels enter LOAD with tgt=stream and the counter cleared.
- Outputs at reset: Load=1, src=0, grant=0, write_en=0, read_en=0, state=2.
- After Resetn rises, the normal LOAD→SETTLE→STREAM start-up follows.

## Timing
- Counter: CNT_W bits, cleared on every state entry, increments each cycle. A phase ends when count == param−1.
- Request-to-grant latency after the boundary: 1 + LOAD_CYCLES + SETTLE_CYCLES cycles.
- Grant release to stream enable: 1 + LOAD_CYCLES + SETTLE_CYCLES cycles after request low.
- All outputs except the enable gates are registered.
- Boundary and request inputs are sampled on the same edge.
- Reset asserted mid-operation aborts any phase immediately; nothing is retained.

## Configuration
Macro: SDRAM_SCHED_TIMEOUT_EN.
- Defined: DRAIN also counts. After TIMEOUT_CYCLES with no boundary, the channel proceeds to LOAD as if a boundary arrived. Covers a stalled camera or disabled LCD.
- Undefined: DRAIN waits for the boundary indefinitely. TIMEOUT_CYCLES is unused.

## Structure
Shared package `sdram_sched_pkg`:
- The state enum and its 3-bit codes.
- The owner encoding (STREAM=0, NIOS=1).

Sub-module `sdram_channel_seq`:
- The per-channel FSM, counter and enable mux.
- Instantiated twice: write channel and read channel.
- The top level adds only LCD_vblank edge detection and port wiring.

## Test plan
Use LOAD_CYCLES=2, SETTLE_CYCLES=8, CNT_W=8.
- Reset released → WR_Load and RD_Load high for 2 cycles, then 8 idle cycles. Wr_state=Rd_state=0 on the 11th cycle; Cam_wr_en passes to SDRAM_write_en.
- Nios_wr_req high, Frame_start 5 cycles later:
  - Wr_state=1 for 5 cycles, then Load for 2 cycles and 8 gated cycles.
  - Wr_grant=1 and SDRAM_wr_src=1; Cam_wr_en is blocked.
- Nios_rd_req high, then LCD_vblank rises:
  - Rd_grant=1 exactly 11 cycles after the rising edge.
  - LCD_rd_en pulses during LOAD/SETTLE never reach SDRAM_read_en.
- Nios_wr_req dropped in DRAIN in the same cycle as Frame_start → Wr_state returns to 0 next cycle; no Load pulse.
- Resetn pulsed low while Wr_state=3 → outputs take reset values asynchronously; the start-up sequence reruns.
- With SDRAM_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, Nios_wr_req held with no Frame_start → LOAD entered after 20 cycles in DRAIN.
